cmp_nbit_seq: RTL and testbench

//  Parametrised multi-cycle magnitude comparator; next generation of the 4-bit

---
 rtl/cmp_nbit_seq_if.sv | 24 ++
 rtl/cmp_nbit_seq.sv | 117 +++++++++++
 tb/tb_cmp_nbit_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_nbit_seq_if.sv
// Handshake and operand bundle for the multi-cycle magnitude comparator.
// Operands use [0:WIDTH-1] ordering with bit 0 as the MSB.
interface cmp_nbit_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             busy;
  logic             done;
  logic             ahigher;
  logic             alower;
  logic             asame;

  modport master (
    output start, a, b,
    input  busy, done, ahigher, alower, asame
  );

  modport slave (
    input  start, a, b,
    output busy, done, ahigher, alower, asame
  );
endinterface

// File: rtl/cmp_nbit_seq.sv
// Multi-cycle magnitude comparator: latches A/B on start, walks DIGIT bits per
// clock from the MSB digit down, and stops at the first differing digit.
// Result flags are one-hot and held until the next accepted start or reset.
module cmp_nbit_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  cmp_nbit_seq_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("cmp_nbit_seq: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [0:WIDTH-1] a_q, a_d;
  logic [0:WIDTH-1] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic             same_q, same_d;
  logic [DIGIT-1:0] da, db;
  int unsigned      off;

  // Select the current digit; in signed mode the top digit's MSB is flipped
  // so negative operands rank below non-negative ones.
  always_comb begin
    off = int'(idx_q) * DIGIT;
    da  = a_q[off +: DIGIT];
    db  = b_q[off +: DIGIT];
    if (SIGNED != 0 && idx_q == '0) begin
      da[DIGIT-1] = ~da[DIGIT-1];
      db[DIGIT-1] = ~db[DIGIT-1];
    end
  end

  // Next-state, operand capture and result-flag logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    same_d  = same_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          hi_d    = 1'b0;
          lo_d    = 1'b0;
          same_d  = 1'b0;
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (da > db) begin
          hi_d    = 1'b1;
          state_d = S_DONE;
        end else if (da < db) begin
          lo_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == IW'(NDIG - 1)) begin
          same_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      same_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      same_q  <= same_d;
    end
  end

  assign bus.busy    = (state_q == S_CMP);
  assign bus.done    = (state_q == S_DONE);
  assign bus.ahigher = hi_q;
  assign bus.alower  = lo_q;
  assign bus.asame   = same_q;

endmodule

// File: tb/tb_cmp_nbit_seq.sv
// Bench for cmp_nbit_seq: three instances (unsigned DIGIT=2, signed DIGIT=2,
// unsigned DIGIT=16) checked against an arithmetic reference model.
module tb_cmp_nbit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic [15:0] a_drv, b_drv;
  int          nchecks = 0;
  int          nfail   = 0;

  always #5 clk = ~clk;

  cmp_nbit_seq_if #(.WIDTH(16)) if0 ();
  cmp_nbit_seq_if #(.WIDTH(16)) if1 ();
  cmp_nbit_seq_if #(.WIDTH(16)) if2 ();

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.a = a_drv;
  assign if0.b = b_drv;
  assign if1.a = a_drv;
  assign if1.b = b_drv;
  assign if2.a = a_drv;
  assign if2.b = b_drv;

  logic [2:0] busy_v, done_v, hi_v, lo_v, same_v;
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  assign hi_v   = {if2.ahigher, if1.ahigher, if0.ahigher};
  assign lo_v   = {if2.alower, if1.alower, if0.alower};
  assign same_v = {if2.asame, if1.asame, if0.asame};

  cmp_nbit_seq #(.WIDTH(16), .DIGIT(2), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  cmp_nbit_seq #(.WIDTH(16), .DIGIT(2), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  cmp_nbit_seq #(.WIDTH(16), .DIGIT(16), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected {ahigher, alower, asame} from a plain numeric compare.
  function automatic logic [2:0] exp_res(input logic [15:0] av, input logic [15:0] bv,
                                         input bit sgn);
    int x, y;
    x = sgn ? int'($signed(av)) : int'(av);
    y = sgn ? int'($signed(bv)) : int'(bv);
    if (x > y)      return 3'b100;
    else if (x < y) return 3'b010;
    else            return 3'b001;
  endfunction

  // Reference: cycles from accept to done = 1 + index of first differing digit.
  function automatic int exp_lat(input logic [15:0] av, input logic [15:0] bv, input int digit);
    int ndig, mask, sh;
    ndig = 16 / digit;
    mask = (1 << digit) - 1;
    for (int k = 0; k < ndig; k++) begin
      sh = 16 - (k + 1) * digit;
      if (((int'(av) >> sh) & mask) != ((int'(bv) >> sh) & mask)) return k + 1;
    end
    return ndig;
  endfunction

  function automatic logic [4:0] outs(input int u);
    return {busy_v[u], done_v[u], hi_v[u], lo_v[u], same_v[u]};
  endfunction

  // One compare on unit u. With inject set, a conflicting start is driven
  // for one cycle from E+1 and must be ignored.
  task automatic do_cmp(input int u, input logic [15:0] av, input logic [15:0] bv,
                        input string tag, input bit inject);
    int  lat;
    bit  seen;
    int  digit;
    bit  sgn;
    lat   = 0;
    seen  = 1'b0;
    digit = (u == 2) ? 16 : 2;
    sgn   = (u == 1);
    @(negedge clk);
    a_drv = av;
    b_drv = bv;
    st[u] = 1'b1;
    @(posedge clk);
    #1;
    st[u] = 1'b0;
    check({tag, " accept"}, 32'(outs(u)), 32'(5'b10000));
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (inject && c == 1) begin
        a_drv = 16'hFFFF;
        b_drv = 16'h0000;
        st[u] = 1'b1;
      end
      if (inject && c == 2) st[u] = 1'b0;
      if (done_v[u]) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(av, bv, digit)));
    check({tag, " result"}, 32'(outs(u)), 32'({2'b01, exp_res(av, bv, sgn)}));
  endtask

  // Idle cycles after a result: no busy/done, flags unchanged.
  task automatic hold_check(input int u, input int n, input logic [2:0] flags, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold"}, 32'(outs(u)), 32'({2'b00, flags}));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    st    = '0;
    a_drv = '0;
    b_drv = '0;
    #1;
    for (int u = 0; u < 3; u++) check("reset outs", 32'(outs(u)), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB digit decides, unsigned vs signed
    do_cmp(0, 16'h8000, 16'h7FFF, "u8000_7fff", 1'b0);
    hold_check(0, 1, 3'b100, "u8000_7fff");
    do_cmp(1, 16'h8000, 16'h7FFF, "s8000_7fff", 1'b0);
    hold_check(1, 1, 3'b010, "s8000_7fff");
    do_cmp(1, 16'hFFFF, 16'hFFFE, "sffff_fffe", 1'b0);
    hold_check(1, 1, 3'b100, "sffff_fffe");

    // equal operands, full-length walk, flags held
    do_cmp(0, 16'hA5A5, 16'hA5A5, "eq_a5a5", 1'b0);
    hold_check(0, 5, 3'b001, "eq_a5a5");
    do_cmp(0, 16'h0001, 16'h0002, "lsb_diff", 1'b0);
    hold_check(0, 1, 3'b010, "lsb_diff");

    // start during compare ignored, then back-to-back start in DONE cycle
    do_cmp(0, 16'h0001, 16'h0002, "ignore_start", 1'b1);
    do_cmp(0, 16'h0300, 16'h0200, "back2back", 1'b0);
    hold_check(0, 3, 3'b100, "back2back");

    // reset mid-compare
    @(negedge clk);
    a_drv = 16'h1234;
    b_drv = 16'h1234;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    check("abort accept", 32'(outs(0)), 32'(5'b10000));
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort reset outs", 32'(outs(0)), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    hold_check(0, 3, 3'b000, "after_abort");
    do_cmp(0, 16'h0010, 16'h0001, "post_reset", 1'b0);

    // randomized: single-cycle unit, then both digit-serial units
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = (i % 10 == 0) ? ra : 16'($urandom);
      do_cmp(2, ra, rb, "rand_d16", 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case (i % 3)
        0: rb = ra;
        1: rb = ra ^ (16'h1 << $urandom_range(15, 0));
        default: rb = 16'($urandom);
      endcase
      do_cmp(i % 2, ra, rb, (i % 2 == 0) ? "rand_u" : "rand_s", 1'b0);
    end
    hold_check(1, 2, exp_res(ra, rb, 1'b1), "rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
